eth_infifo_reader: RTL
======================

# eth_infifo_reader

AXI4 read-master that drains received Ethernet frames from the ethernet wrapper's INFIFO slave port and presents them as a byte-qualified stream. Software or a sequencer issues one command per frame, with the frame length in bytes. The block splits the transfer into single-outstanding INCR read bursts, repacks the data into a stream with `tkeep`/`tlast`, and reports completion and response errors. It sits directly on the `eth_infifo_s_*` read channels and consumes what the MAC receive path produces.

## Interface
Parameters:
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 32, AXI/stream data width; must be 32 or 64
- `ID_W`, 8, AXI ID width
- `MAX_BURST`, 16, maximum beats per burst (1..256)
- `BASE_ADDR`, 'h0, INFIFO read address, driven on every burst
- `AR_ID`, 0, constant `arid` value

Ports (the design uses one clock; reset is synchronous and active-high):
- `clk_axi` in 1: AXI clock, all logic on the rising edge
- `rst_axi` in 1: synchronous, active-high reset
- `cmd_valid` in 1: command request
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`
- `cmd_len` in 16: frame length in bytes
- `arid` out ID_W
- `araddr` out ADDR_W
- `arlen` out 8
- `arsize` out 3
- `arburst` out 2
- `arvalid` out 1
- `arready` in 1
- `rid` in ID_W: not checked
- `rdata` in DATA_W
- `rresp` in 2
- `rlast` in 1
- `rvalid` in 1
- `rready` out 1
- `m_tdata` out DATA_W
- `m_tkeep` out DATA_W/8
- `m_tlast` out 1
- `m_tvalid` out 1
- `m_tready` in 1
- `done` out 1: one-cycle completion pulse
- `err` out 1: sticky error flag for the last command, valid while `done` is high

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - AR: `arvalid`=1.
  - DATA: `rready` follows the rule below.
  - DONE: waits for the output register to drain, then pulses `done`.
- On a command handshake:
  - Capture `beats_left` = ceil(`cmd_len`/BYTES), where BYTES = DATA_W/8. Width is 17 bits; there is no overflow.
  - Capture `tail` = `cmd_len` mod BYTES.
  - Clear `err`, then go to AR.
  - If `cmd_len`=0, go straight to DONE. No AXI traffic is issued.
- AR state:
  - `arlen` = min(`beats_left`, MAX_BURST) − 1.
  - `araddr`=BASE_ADDR, `arburst`=INCR (2'b01), `arsize`=log2(BYTES), `arid`=AR_ID.
  - The AR fields are held stable while `arvalid` is high.
  - On `arready`, load `burst_cnt` = `arlen`+1 and go to DATA.
- DATA state:
  - `rready` = !`m_tvalid` || `m_tready`. This is a single output register with no skid buffer.
  - On each R handshake, load the output register with `rdata` and decrement `burst_cnt` and `beats_left`.
  - `m_tlast`=1 only on the beat that brings `beats_left` to 0.
  - On that beat, `m_tkeep` = low `tail` bits set, or all ones if `tail`=0. All other beats carry all-ones `tkeep`.
  - When `burst_cnt` reaches 0: go to AR if `beats_left`>0, else DONE.
- Only one burst is outstanding at any time. A new AR is never issued before the previous burst's final beat.
- Error capture:
  - `rresp` ≠ OKAY on any beat sets `err`. The data is still forwarded.
  - `rlast` not matching the internal count (early or missing) sets `err`.
  - Burst termination always follows the internal count, never `rlast`.
- DONE state: once `m_tvalid`=0 (last beat consumed), assert `done` for exactly one cycle and return to IDLE.

## Timing
- Reset values:
  - `arvalid`, `rready`, `m_tvalid`, `m_tlast`, `done`, `err` = 0.
  - `m_tkeep`, `m_tdata`, `arlen` = 0.
  - State = IDLE, so `cmd_ready`=1 from the first cycle after reset.
- Latencies:
  - Command handshake at cycle T → `arvalid` high at T+1.
  - R handshake at T → `m_tvalid` high at T+1.
  - `m_tlast` consumed at T → `done` at T+1.
  - Zero-length command at T → `done` at T+2.
- Throughput: full rate (1 beat/cycle) while `m_tready` is held high. There is a minimum 1-cycle AR gap between bursts.
- `m_tvalid` stays asserted with stable data until `m_tready`. `arvalid` never drops before `arready`.
- `rst_axi` mid-operation: the next cycle is IDLE with all outputs at reset values. The pending frame is discarded, no `done` is issued, and the in-flight burst is abandoned.
- A command presented outside IDLE is not accepted (`cmd_ready`=0).

## Test plan
- `cmd_len`=64, DATA_W=32, MAX_BURST=16, `m_tready`=1, zero-wait slave → one AR with `arlen`=15; 16 beats; `tlast` on beat 16 with `tkeep`=4'hF; `done` one cycle after; `err`=0.
- `cmd_len`=70 → two ARs (`arlen`=15, then 1); 18 beats total; last beat `tkeep`=4'b0011, `tlast`=1; no other `tlast`.
- `cmd_len`=0 → no `arvalid` ever; `done` 2 cycles after the handshake; `m_tvalid` stays 0.
- `cmd_len`=8, slave returns `rresp`=SLVERR on beat 1 → both beats forwarded; `done`=1 with `err`=1. The next clean 8-byte command ends with `err`=0.
- Random `m_tready` (50%) and random `arready`/`rvalid` delays over 1000 frames of length 1..1518 → byte-exact stream vs reference FIFO; AR stable while waiting; at most one burst outstanding.
- `rst_axi` asserted for 1 cycle mid-burst of a 256-byte frame → `m_tvalid`/`arvalid`/`rready` 0 next cycle; no `done`; `cmd_ready`=1; a subsequent 4-byte command completes normally.

Source files
------------

// File: rtl/eth_infifo_reader.sv
// AXI4 read master that drains Ethernet frames from the INFIFO slave port.
// Each command moves one frame as a byte-qualified stream with tkeep/tlast.
module eth_infifo_reader #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                ID_W      = 8,
  parameter int                MAX_BURST = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ID_W-1:0]   AR_ID     = '0
) (
  input  logic                clk_axi,
  input  logic                rst_axi,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [15:0]         cmd_len,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                done,
  output logic                err,
  output logic [1:0]          dbg_state
);

  localparam int BYTES  = DATA_W / 8;
  localparam int SIZE_W = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA, S_DONE} state_t;

  state_t               state;
  logic [16:0]          beats_left;
  logic [SIZE_W-1:0]    tail;
  logic [8:0]           burst_cnt;
  logic [16:0]          cmd_beats;
  logic [BYTES-1:0]     keep_last;
  logic                 r_hs;
  logic                 last_beat;
  logic                 burst_end;
  logic                 unused_rid;

  function automatic logic [7:0] burst_len(input logic [16:0] beats);
    logic [16:0] n;
    n = (beats > 17'(MAX_BURST)) ? 17'(MAX_BURST) : beats;
    return 8'(n - 17'd1);
  endfunction

  assign cmd_beats = ({1'b0, cmd_len} + 17'(BYTES - 1)) >> SIZE_W;

  always_comb begin
    keep_last = '0;
    for (int i = 0; i < BYTES; i++) begin
      keep_last[i] = (tail == '0) || (i < int'(tail));
    end
  end

  // Handshakes are valid/ready: a transfer happens on a rising edge where both are high;
  // valid never drops and its payload never changes until that edge.
  assign cmd_ready  = (state == S_IDLE);
  assign rready     = (state == S_DATA) && (!m_tvalid || m_tready);
  assign r_hs       = rvalid && rready;
  assign last_beat  = (beats_left == 17'd1);
  assign burst_end  = (burst_cnt == 9'd1);
  assign araddr     = BASE_ADDR;
  assign arburst    = 2'b01;
  assign arsize     = 3'(SIZE_W);
  assign arid       = AR_ID;
  assign dbg_state  = state;
  assign unused_rid = ^rid;

  always_ff @(posedge clk_axi) begin
    if (rst_axi) begin
      state      <= S_IDLE;
      arvalid    <= 1'b0;
      arlen      <= '0;
      beats_left <= '0;
      tail       <= '0;
      burst_cnt  <= '0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tlast    <= 1'b0;
      m_tvalid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (m_tvalid && m_tready) m_tvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            beats_left <= cmd_beats;
            tail       <= cmd_len[SIZE_W-1:0];
            err        <= 1'b0;
            if (cmd_len == 16'd0) begin
              state <= S_DONE;
            end else begin
              arlen   <= burst_len(cmd_beats);
              arvalid <= 1'b1;
              state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid   <= 1'b0;
            burst_cnt <= {1'b0, arlen} + 9'd1;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_hs) begin
            m_tdata    <= rdata;
            m_tvalid   <= 1'b1;
            m_tlast    <= last_beat;
            m_tkeep    <= last_beat ? keep_last : '1;
            beats_left <= beats_left - 17'd1;
            burst_cnt  <= burst_cnt - 9'd1;
            // The internal count ends the burst; rlast is only cross-checked.
            if (rresp != 2'b00 || rlast != burst_end) err <= 1'b1;
            if (burst_end) begin
              if (!last_beat) begin
                arlen   <= burst_len(beats_left - 17'd1);
                arvalid <= 1'b1;
                state   <= S_AR;
              end else begin
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (!m_tvalid || m_tready) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
